// File: rtl/accel_pkt_rx.sv
// Serial accelerometer packet receiver: 8N1 byte receiver plus two-byte packet
// tracker producing a 14-bit sample with valid/error pulses and inter-byte timeout.
module accel_pkt_rx #(
  parameter int BAUD_DIV = 868,
  parameter int IBTO     = 17360
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX_A,
  output logic [13:0] Xmeas,
  output logic        accel_vld,
  output logic        frm_err
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int TW = $clog2(IBTO + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(IBTO - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(IBTO);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] START   = 3'd1;
  localparam logic [2:0] DATA    = 3'd2;
  localparam logic [2:0] STOP    = 3'd3;
  localparam logic [2:0] WAIT_HI = 3'd4;

  logic          rx_meta_r, rx_sync_r, rx_prev_r;
  logic [2:0]    state_r, state_nx;
  logic [CW-1:0] baud_cnt_r, baud_nx;
  logic [2:0]    bit_idx_r, bit_nx;
  logic [7:0]    shift_r, shift_nx;
  logic          byte_ok_s, stop_bad_s, start_det_s, to_hit_s;
  logic          expect_lo_r, to_run_r;
  logic [6:0]    hi_r;
  logic [TW-1:0] to_cnt_r;

  // Two-flop synchronizer plus previous-value flop for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= RX_A;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Byte receiver next-state logic; the bit counter is cleared whenever it reaches its terminal value
  always_comb begin
    state_nx    = state_r;
    baud_nx     = baud_cnt_r;
    bit_nx      = bit_idx_r;
    shift_nx    = shift_r;
    byte_ok_s   = 1'b0;
    stop_bad_s  = 1'b0;
    start_det_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (rx_prev_r && !rx_sync_r) begin
          start_det_s = 1'b1;
          state_nx    = START;
          baud_nx     = {CW{1'b0}};
        end else begin
          state_nx = IDLE;
        end
      end
      START: begin
        if (baud_cnt_r == HALF_M1) begin
          baud_nx  = {CW{1'b0}};
          bit_nx   = 3'd0;
          state_nx = rx_sync_r ? IDLE : DATA;
        end else begin
          baud_nx = baud_cnt_r + CW'(1);
        end
      end
      DATA: begin
        if (baud_cnt_r == FULL_M1) begin
          baud_nx  = {CW{1'b0}};
          shift_nx = {rx_sync_r, shift_r[7:1]};
          bit_nx   = bit_idx_r + 3'd1;
          state_nx = (bit_idx_r == 3'd7) ? STOP : DATA;
        end else begin
          baud_nx = baud_cnt_r + CW'(1);
        end
      end
      STOP: begin
        if (baud_cnt_r == FULL_M1) begin
          baud_nx = {CW{1'b0}};
          if (rx_sync_r) begin
            byte_ok_s = 1'b1;
            state_nx  = IDLE;
          end else begin
            stop_bad_s = 1'b1;
            state_nx   = WAIT_HI;
          end
        end else begin
          baud_nx = baud_cnt_r + CW'(1);
        end
      end
      WAIT_HI: begin
        if (rx_sync_r) begin
          state_nx = IDLE;
        end else begin
          state_nx = WAIT_HI;
        end
      end
      default: begin
        state_nx = IDLE;
        baud_nx  = {CW{1'b0}};
      end
    endcase
  end

  // Byte receiver state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      baud_cnt_r <= {CW{1'b0}};
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
    end else begin
      state_r    <= state_nx;
      baud_cnt_r <= baud_nx;
      bit_idx_r  <= bit_nx;
      shift_r    <= shift_nx;
    end
  end

  // A start detect in the same cycle wins over the timeout, so a byte that just made it is not flagged
  assign to_hit_s = to_run_r && !start_det_s && (to_cnt_r == TO_LAST);

  // Packet tracker, inter-byte timeout and registered outputs; at most one pulse source fires per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expect_lo_r <= 1'b0;
      hi_r        <= 7'h00;
      to_run_r    <= 1'b0;
      to_cnt_r    <= {TW{1'b0}};
      Xmeas       <= 14'h0000;
      accel_vld   <= 1'b0;
      frm_err     <= 1'b0;
    end else begin
      accel_vld <= 1'b0;
      frm_err   <= 1'b0;
      if (stop_bad_s) begin
        frm_err     <= 1'b1;
        expect_lo_r <= 1'b0;
        to_run_r    <= 1'b0;
        to_cnt_r    <= {TW{1'b0}};
      end else if (byte_ok_s) begin
        if (shift_r[7]) begin
          hi_r        <= shift_r[6:0];
          frm_err     <= expect_lo_r;
          expect_lo_r <= 1'b1;
          to_run_r    <= 1'b1;
          to_cnt_r    <= {TW{1'b0}};
        end else begin
          if (expect_lo_r) begin
            Xmeas     <= {hi_r, shift_r[6:0]};
            accel_vld <= 1'b1;
          end else begin
            frm_err <= 1'b1;
          end
          expect_lo_r <= 1'b0;
          to_run_r    <= 1'b0;
          to_cnt_r    <= {TW{1'b0}};
        end
      end else if (to_hit_s) begin
        frm_err     <= 1'b1;
        expect_lo_r <= 1'b0;
        to_run_r    <= 1'b0;
        to_cnt_r    <= TO_MAX;
      end else if (start_det_s) begin
        to_run_r <= 1'b0;
      end else if (to_run_r) begin
        to_cnt_r <= to_cnt_r + TW'(1);
      end else begin
        to_run_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_accel_pkt_rx.sv
// Self-checking bench for accel_pkt_rx: table of packets plus hand-written
// error, timeout, glitch and reset sequences, checked through a pulse scoreboard.
module tb_accel_pkt_rx;

  localparam int BD = 16;
  localparam int TO = 320;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX_A = 1'b1;
  logic [13:0] Xmeas;
  logic        accel_vld;
  logic        frm_err;

  typedef struct { logic is_err; logic [13:0] xm; } exp_t;
  typedef struct { logic [7:0] hi; logic [7:0] lo; logic [13:0] xm; } vec_t;

  exp_t        sbq[$];
  vec_t        vecs[5];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          vld_cyc = 0;
  int          t0;
  int          lat;
  logic [13:0] last_x;

  always #5 clk = ~clk;

  accel_pkt_rx #(.BAUD_DIV(BD), .IBTO(TO)) dut (
    .clk(clk), .rst_n(rst_n), .RX_A(RX_A),
    .Xmeas(Xmeas), .accel_vld(accel_vld), .frm_err(frm_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    RX_A = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX_A = b[i];
      repeat (BD) @(negedge clk);
    end
    RX_A = stop_bit;
    repeat (BD) @(negedge clk);
    RX_A = 1'b1;
  endtask

  task automatic expect_vld(input logic [13:0] x);
    exp_t e;
    e.is_err = 1'b0;
    e.xm     = x;
    sbq.push_back(e);
    last_x = x;
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1;
    e.xm     = last_x;
    sbq.push_back(e);
  endtask

  initial begin
    vecs[0] = '{8'h9A, 8'h35, 14'h0D35};
    vecs[1] = '{8'hFF, 8'h00, 14'h3F80};
    vecs[2] = '{8'h80, 8'h7F, 14'h007F};
    vecs[3] = '{8'hD5, 8'h2A, 14'h2AAA};
    vecs[4] = '{8'hAB, 8'h55, 14'h15D5};
    last_x  = 14'h0000;

    // pulse monitor: every accel_vld/frm_err pulse must match the scoreboard head
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        cyc++;
        if (rst_n) begin
          if (accel_vld && frm_err) begin
            check("pulse_exclusive", 32'd1, 32'd0);
          end else if (accel_vld || frm_err) begin
            if (accel_vld) vld_cyc = cyc;
            if (sbq.size() == 0) begin
              check("unexpected_pulse", {30'd0, accel_vld, frm_err}, 32'd0);
            end else begin
              e = sbq.pop_front();
              check("pulse_kind_err", {31'd0, frm_err}, {31'd0, e.is_err});
              check("xmeas_at_pulse", {18'd0, Xmeas}, {18'd0, e.xm});
            end
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check("reset_xmeas", {18'd0, Xmeas}, 32'd0);
    check("reset_vld", {31'd0, accel_vld}, 32'd0);
    check("reset_err", {31'd0, frm_err}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // good first byte, bad stop on second, then a clean packet
    send_byte(8'h9A, 1'b1);
    expect_err();
    send_byte(8'h35, 1'b0);
    repeat (BD) @(negedge clk);
    check("hold_after_bad_stop", {18'd0, Xmeas}, 32'd0);
    expect_vld(14'h00FF);
    send_byte(8'h81, 1'b1);
    send_byte(8'h7F, 1'b1);
    repeat (BD) @(negedge clk);

    // back-to-back packet latency
    t0 = cyc;
    expect_vld(14'h0D35);
    send_byte(8'h9A, 1'b1);
    send_byte(8'h35, 1'b1);
    repeat (BD) @(negedge clk);
    lat = vld_cyc - t0;
    check("latency_in_window",
          {31'd0, (lat >= 19 * BD + BD / 2 - 2) && (lat <= 20 * BD + 4)}, 32'd1);

    // sustained back-to-back packets from the table
    for (int i = 0; i < 5; i++) begin
      expect_vld(vecs[i].xm);
      send_byte(vecs[i].hi, 1'b1);
      send_byte(vecs[i].lo, 1'b1);
    end
    repeat (BD) @(negedge clk);

    // lone second byte, then a clean packet
    expect_err();
    send_byte(8'h35, 1'b1);
    expect_vld(14'h3F80);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (BD) @(negedge clk);

    // repeated first byte replaces hi
    send_byte(8'h9A, 1'b1);
    expect_err();
    send_byte(8'h85, 1'b1);
    expect_vld(14'h0292);
    send_byte(8'h12, 1'b1);
    repeat (BD) @(negedge clk);

    // inter-byte timeout, then the orphaned second byte
    send_byte(8'h9A, 1'b1);
    expect_err();
    repeat (TO + 1) @(negedge clk);
    expect_err();
    send_byte(8'h35, 1'b1);
    repeat (BD) @(negedge clk);
    check("hold_after_timeout", {18'd0, Xmeas}, {18'd0, last_x});

    // short low glitch must be ignored, then a clean packet
    RX_A = 1'b0;
    repeat (BD / 4) @(negedge clk);
    RX_A = 1'b1;
    repeat (2 * BD) @(negedge clk);
    expect_vld(14'h2001);
    send_byte(8'hC0, 1'b1);
    send_byte(8'h01, 1'b1);
    repeat (BD) @(negedge clk);

    // reset part way through the second byte
    send_byte(8'h9A, 1'b1);
    RX_A = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      RX_A = (i == 1) ? 1'b0 : 1'b1;
      repeat (BD) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("midreset_xmeas", {18'd0, Xmeas}, 32'd0);
    check("midreset_vld", {31'd0, accel_vld}, 32'd0);
    check("midreset_err", {31'd0, frm_err}, 32'd0);
    check("midreset_queue_empty", sbq.size(), 32'd0);
    RX_A = 1'b1;
    last_x = 14'h0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * BD) @(negedge clk);
    expect_vld(14'h0D35);
    send_byte(8'h9A, 1'b1);
    send_byte(8'h35, 1'b1);
    repeat (2 * BD) @(negedge clk);

    check("scoreboard_drained", sbq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
